cache_mem_arbiter: RTL and testbench
====================================

Name: cache_mem_arbiter

Overview:
- Arbitrates the icache fill port and the dcache fill/writeback port onto one shared single-word RAM port.
- Sits between the caches wrapper (icache + dcache) and the memory.
- Registered grant FSM with fixed dcache priority.
- Request address, write data and direction are latched for the whole RAM access.

Parameters:
ADDR_W, 32, address width in bits
WORD_W, 32, data word width in bits
MAX_DWINS, 4, consecutive dcache grants allowed while icache waits (used only with the optional feature)

Ports:
CLK  in  1  clock, rising edge
RST  in  1  asynchronous active-high reset
iREN  in  1  icache read request
iaddr  in  ADDR_W  icache address
iload  out  WORD_W  icache read data
iwait  out  1  low for exactly the completion cycle of an icache access
dREN  in  1  dcache read request
dWEN  in  1  dcache write request
daddr  in  ADDR_W  dcache address
dstore  in  WORD_W  dcache write data
dload  out  WORD_W  dcache read data
dwait  out  1  low for exactly the completion cycle of a dcache access
ramREN  out  1  RAM read strobe
ramWEN  out  1  RAM write strobe
ramaddr  out  ADDR_W  RAM address
ramstore  out  WORD_W  RAM write data
ramload  in  WORD_W  RAM read data, valid when ram_ready=1
ram_ready  in  1  RAM access complete this cycle

Behaviour:
- Reset (async, RST=1):
  - state=IDLE; ramREN=ramWEN=0; ramaddr=ramstore=0.
  - iwait=dwait=1; latched registers=0; dwin counter=0.
- FSM states: IDLE, IGRANT, DGRANT.
- IDLE:
  - dREN|dWEN -> DGRANT; else iREN -> IGRANT; else stay.
  - On entering a grant, latch addr, store data and we into the grant registers.
  - dREN&dWEN together is treated as a write.
- Grant states:
  - Drive ramaddr/ramstore from the latched registers.
  - ramREN=~we, ramWEN=we; both stay asserted until ram_ready.
  - ram_ready=1 in DGRANT: dwait=0 for that cycle only; next state IDLE.
  - ram_ready=1 in IGRANT: iwait=0 for that cycle only; next state IDLE.
- Outputs iload and dload are combinational from ramload; meaningful only when the matching wait is low.
- Latency:
  - Request seen in IDLE at cycle N; RAM strobes from N+1.
  - With ram_ready at N+1+L, the wait output is low at N+1+L.
  - Minimum total is 2 cycles (L=0); one IDLE bubble follows every access.
- Abort: requester drops its request in its grant state before ram_ready -> strobes drop next cycle, return to IDLE, no wait pulse.
- Inputs changing mid-grant (address or data) are ignored; the latched copy is used.
- ram_ready outside a grant state is ignored.
- iwait and dwait are never low in the same cycle.
- Only the granted requester's wait can go low.
- Reset mid-access: strobes drop immediately (async); no completion is reported.

Optional Feature:
Macro ARB_ISTARVE_GUARD_EN.
- Defined:
  - Counter dwin increments on each DGRANT completion while iREN=1; it clears on any IGRANT completion.
  - When dwin==MAX_DWINS and iREN=1, IDLE chooses IGRANT even if a dcache request is pending.
  - Counter saturates at MAX_DWINS.
- Undefined:
  - Strict dcache priority; counter logic is absent.
  - The icache may starve indefinitely.

Test Plan:
- Reset: RST=1 mid-run -> ramREN=ramWEN=0, iwait=dwait=1 in the same cycle; state IDLE after release.
- Single icache read:
  - Stimulus: iREN=1, iaddr=0x40, RAM latency 2, ramload=0xDEADBEEF.
  - Required: ramREN high from cycle 1, ramaddr=0x40; iwait=0 at cycle 3 with iload=0xDEADBEEF; IDLE at cycle 4.
- Simultaneous requests:
  - Stimulus: iREN=1 and dWEN=1, daddr=0x100, dstore=0x12345678 in the same cycle.
  - Required: DGRANT first with ramWEN=1, ramstore=0x12345678; dwait pulse; then IGRANT; iwait pulse afterwards.
- Latching: change daddr 0x100->0x200 mid-grant -> ramaddr stays 0x100 until ram_ready.
- Abort: dREN drops before ram_ready in DGRANT -> ramREN=0 next cycle, no dwait low pulse, pending iREN is then granted.
- Starvation guard:
  - Stimulus: ARB_ISTARVE_GUARD_EN defined, MAX_DWINS=4, dREN and iREN held high.
  - Required: exactly 4 dcache completions, then 1 icache completion, then dcache again.
  - Without the macro: zero icache completions.

Source files
------------

// File: rtl/cache_mem_arbiter.sv
// Shares one single-word RAM port between the icache fill port and the dcache fill/writeback port.
// Build option: define ARB_ISTARVE_GUARD_EN to cap consecutive dcache grants while the icache waits.
module cache_mem_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int WORD_W    = 32,
  parameter int MAX_DWINS = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic [WORD_W-1:0] iload,
  output logic              iwait,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [WORD_W-1:0] dstore,
  output logic [WORD_W-1:0] dload,
  output logic              dwait,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [WORD_W-1:0] ramstore,
  input  logic [WORD_W-1:0] ramload,
  input  logic              ram_ready
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IGRANT = 2'd1,
    DGRANT = 2'd2
  } state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [WORD_W-1:0] store_reg, store_next;
  logic              we_reg, we_next;

  logic d_req;
  logic pick_i;

  // A simultaneous read and write request from the dcache is a write.
  assign d_req = dREN | dWEN;

  assign iload = ramload;
  assign dload = ramload;

`ifdef ARB_ISTARVE_GUARD_EN
  localparam int DWIN_W = (MAX_DWINS < 1) ? 1 : $clog2(MAX_DWINS + 1);
  localparam logic [DWIN_W-1:0] DWIN_MAX = DWIN_W'(MAX_DWINS);

  logic [DWIN_W-1:0] dwin_reg, dwin_next;

  // Once the dcache has won MAX_DWINS times in a row against a waiting icache, the icache goes next.
  assign pick_i = iREN & (~d_req | (dwin_reg == DWIN_MAX));

  always_comb begin
    dwin_next = dwin_reg;
    if (state_reg == IGRANT && ram_ready) begin
      dwin_next = '0;
    end else if (state_reg == DGRANT && ram_ready && iREN && dwin_reg != DWIN_MAX) begin
      dwin_next = dwin_reg + DWIN_W'(1);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      dwin_reg <= '0;
    end else begin
      dwin_reg <= dwin_next;
    end
  end
`else
  // MAX_DWINS only matters when the starvation guard is built in.
  localparam int unused_max_dwins = MAX_DWINS;

  assign pick_i = iREN & ~d_req;
`endif

  always_comb begin
    state_next = state_reg;
    addr_next  = addr_reg;
    store_next = store_reg;
    we_next    = we_reg;
    ramREN     = 1'b0;
    ramWEN     = 1'b0;
    ramaddr    = '0;
    ramstore   = '0;
    iwait      = 1'b1;
    dwait      = 1'b1;

    case (state_reg)
      IDLE: begin
        if (pick_i) begin
          state_next = IGRANT;
          addr_next  = iaddr;
          store_next = '0;
          we_next    = 1'b0;
        end else if (d_req) begin
          state_next = DGRANT;
          addr_next  = daddr;
          store_next = dstore;
          we_next    = dWEN;
        end
      end

      IGRANT: begin
        ramREN   = ~we_reg;
        ramWEN   = we_reg;
        ramaddr  = addr_reg;
        ramstore = store_reg;
        if (ram_ready) begin
          iwait      = 1'b0;
          state_next = IDLE;
        end else if (!iREN) begin
          state_next = IDLE;
        end
      end

      DGRANT: begin
        ramREN   = ~we_reg;
        ramWEN   = we_reg;
        ramaddr  = addr_reg;
        ramstore = store_reg;
        // Completion wins over a request dropped in the same cycle.
        if (ram_ready) begin
          dwait      = 1'b0;
          state_next = IDLE;
        end else if (!d_req) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg <= IDLE;
      addr_reg  <= '0;
      store_reg <= '0;
      we_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      addr_reg  <= addr_next;
      store_reg <= store_next;
      we_reg    <= we_next;
    end
  end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Self-checking bench for cache_mem_arbiter: directed scenarios plus a randomized run
// compared against a transaction-level model of the arbitration rules.
module tb_cache_mem_arbiter;

  localparam int ADDR_W    = 32;
  localparam int WORD_W    = 32;
  localparam int MAX_DWINS = 4;
`ifdef ARB_ISTARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic              CLK = 1'b0;
  logic              RST;
  logic              iREN;
  logic [ADDR_W-1:0] iaddr;
  logic [WORD_W-1:0] iload;
  logic              iwait;
  logic              dREN;
  logic              dWEN;
  logic [ADDR_W-1:0] daddr;
  logic [WORD_W-1:0] dstore;
  logic [WORD_W-1:0] dload;
  logic              dwait;
  logic              ramREN;
  logic              ramWEN;
  logic [ADDR_W-1:0] ramaddr;
  logic [WORD_W-1:0] ramstore;
  logic [WORD_W-1:0] ramload;
  logic              ram_ready;

  int checks = 0;
  int errors = 0;

  cache_mem_arbiter #(
    .ADDR_W   (ADDR_W),
    .WORD_W   (WORD_W),
    .MAX_DWINS(MAX_DWINS)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .iREN     (iREN),
    .iaddr    (iaddr),
    .iload    (iload),
    .iwait    (iwait),
    .dREN     (dREN),
    .dWEN     (dWEN),
    .daddr    (daddr),
    .dstore   (dstore),
    .dload    (dload),
    .dwait    (dwait),
    .ramREN   (ramREN),
    .ramWEN   (ramWEN),
    .ramaddr  (ramaddr),
    .ramstore (ramstore),
    .ramload  (ramload),
    .ram_ready(ram_ready)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive on the falling edge, then sample 1 time unit later.
  task automatic cyc();
    @(negedge CLK);
  endtask

  // Transaction-level reference: the access in flight (if any) and the dcache win streak.
  bit          m_active;
  bit          m_is_d;
  bit          m_we;
  logic [31:0] m_addr;
  logic [31:0] m_data;
  int          m_wins;

  bit comp_is_i[$];
  int icount;

  initial begin
    RST = 1'b1; iREN = 0; iaddr = 0; dREN = 0; dWEN = 0; daddr = 0; dstore = 0;
    ramload = 0; ram_ready = 0;

    // Reset state
    cyc(); cyc(); #1;
    check("rst_ramREN", ramREN, 0);
    check("rst_ramWEN", ramWEN, 0);
    check("rst_iwait", iwait, 1);
    check("rst_dwait", dwait, 1);
    check("rst_ramaddr", ramaddr, 0);
    check("rst_ramstore", ramstore, 0);
    RST = 1'b0;

    // Single icache read, RAM latency 2
    cyc(); iREN = 1; iaddr = 32'h40; #1;
    check("ird_c0_ramREN", ramREN, 0);
    cyc(); #1;
    check("ird_c1_ramREN", ramREN, 1);
    check("ird_c1_ramWEN", ramWEN, 0);
    check("ird_c1_ramaddr", ramaddr, 32'h40);
    check("ird_c1_iwait", iwait, 1);
    cyc(); #1;
    check("ird_c2_ramREN", ramREN, 1);
    cyc(); ram_ready = 1; ramload = 32'hDEADBEEF; #1;
    check("ird_c3_iwait", iwait, 0);
    check("ird_c3_dwait", dwait, 1);
    check("ird_c3_iload", iload, 32'hDEADBEEF);
    cyc(); ram_ready = 0; iREN = 0; #1;
    check("ird_c4_ramREN", ramREN, 0);
    check("ird_c4_iwait", iwait, 1);

    // Simultaneous requests: dcache write first, then icache; address latching
    cyc(); iREN = 1; iaddr = 32'h80; dWEN = 1; daddr = 32'h100; dstore = 32'h12345678; #1;
    check("sim_idle_ramWEN", ramWEN, 0);
    cyc(); #1;
    check("sim_d_ramWEN", ramWEN, 1);
    check("sim_d_ramREN", ramREN, 0);
    check("sim_d_ramaddr", ramaddr, 32'h100);
    check("sim_d_ramstore", ramstore, 32'h12345678);
    cyc(); daddr = 32'h200; dstore = 32'hCAFEF00D; #1;
    check("latch_ramaddr", ramaddr, 32'h100);
    check("latch_ramstore", ramstore, 32'h12345678);
    cyc(); ram_ready = 1; #1;
    check("sim_dwait", dwait, 0);
    check("sim_iwait_hold", iwait, 1);
    cyc(); ram_ready = 0; dWEN = 0; #1;
    check("sim_bubble_ramWEN", ramWEN, 0);
    check("sim_bubble_ramREN", ramREN, 0);
    cyc(); #1;
    check("sim_i_ramREN", ramREN, 1);
    check("sim_i_ramaddr", ramaddr, 32'h80);
    cyc(); ram_ready = 1; ramload = 32'h0BADF00D; #1;
    check("sim_iwait", iwait, 0);
    check("sim_dwait_hold", dwait, 1);
    check("sim_iload", iload, 32'h0BADF00D);
    cyc(); ram_ready = 0; iREN = 0; #1;
    check("sim_end_ramREN", ramREN, 0);

    // Abort: dcache drops its read mid-grant, pending icache then served
    cyc(); dREN = 1; daddr = 32'h300; #1;
    cyc(); #1;
    check("abt_ramREN", ramREN, 1);
    check("abt_ramaddr", ramaddr, 32'h300);
    cyc(); dREN = 0; iREN = 1; iaddr = 32'h44; #1;
    check("abt_dwait_drop", dwait, 1);
    cyc(); #1;
    check("abt_next_ramREN", ramREN, 0);
    check("abt_next_dwait", dwait, 1);
    cyc(); #1;
    check("abt_i_ramREN", ramREN, 1);
    check("abt_i_ramaddr", ramaddr, 32'h44);
    cyc(); ram_ready = 1; #1;
    check("abt_iwait", iwait, 0);
    check("abt_dwait", dwait, 1);
    cyc(); ram_ready = 0; iREN = 0;

    // Reset in the middle of a dcache write
    cyc(); dWEN = 1; daddr = 32'h500; dstore = 32'h55; #1;
    cyc(); #1;
    check("rmid_pre_ramWEN", ramWEN, 1);
    cyc(); RST = 1; ram_ready = 1; #1;
    check("rmid_ramWEN", ramWEN, 0);
    check("rmid_ramREN", ramREN, 0);
    check("rmid_dwait", dwait, 1);
    check("rmid_iwait", iwait, 1);
    check("rmid_ramaddr", ramaddr, 0);
    cyc(); RST = 0; dWEN = 0; ram_ready = 0; #1;
    check("rmid_post_ramWEN", ramWEN, 0);
    cyc(); #1;
    check("rmid_idle_ramREN", ramREN, 0);

    // Both requesters held, zero-latency RAM: starvation behaviour
    cyc(); dREN = 1; iREN = 1; ram_ready = 1; daddr = 32'h600; iaddr = 32'h700;
    for (int c = 0; c < 40; c++) begin
      if (c > 0) cyc();
      #1;
      check("starve_excl", {31'd0, iwait | dwait}, 1);
      if (!dwait) comp_is_i.push_back(1'b0);
      if (!iwait) comp_is_i.push_back(1'b1);
    end
    check("starve_ncomp", comp_is_i.size(), 20);
    icount = 0;
    for (int j = 0; j < comp_is_i.size(); j++) begin
      check($sformatf("starve_owner%0d", j), {31'd0, comp_is_i[j]}, {31'd0, GUARD && (j % 5 == 4)});
      if (comp_is_i[j]) icount++;
    end
    check("starve_icount", icount, GUARD ? 4 : 0);
    cyc(); dREN = 0; iREN = 0; ram_ready = 0;

    // Randomized run against the reference model
    cyc(); RST = 1;
    cyc(); RST = 0;
    m_active = 0; m_is_d = 0; m_we = 0; m_addr = 0; m_data = 0; m_wins = 0;
    for (int n = 0; n < 3000; n++) begin
      bit exp_iw, exp_dw, guard_hit;
      logic [1:0] r;
      cyc();
      if ($urandom_range(0, 3) == 0) iREN = ~iREN;
      if ($urandom_range(0, 3) == 0) begin
        r = 2'($urandom_range(0, 3));
        dREN = r[0];
        dWEN = r[1];
      end
      iaddr     = $urandom;
      daddr     = $urandom;
      dstore    = $urandom;
      ramload   = $urandom;
      ram_ready = ($urandom_range(0, 2) == 0);
      #1;
      exp_iw = !(m_active && !m_is_d && ram_ready);
      exp_dw = !(m_active && m_is_d && ram_ready);
      check("rnd_ramREN", ramREN, m_active && !m_we);
      check("rnd_ramWEN", ramWEN, m_active && m_we);
      check("rnd_iwait", iwait, exp_iw);
      check("rnd_dwait", dwait, exp_dw);
      if (m_active) check("rnd_ramaddr", ramaddr, m_addr);
      if (m_active && m_we) check("rnd_ramstore", ramstore, m_data);
      if (!exp_iw) check("rnd_iload", iload, ramload);
      if (!exp_dw) check("rnd_dload", dload, ramload);

      if (m_active) begin
        if (ram_ready) begin
          if (m_is_d) begin
            if (iREN && m_wins < MAX_DWINS) m_wins++;
          end else begin
            m_wins = 0;
          end
          m_active = 0;
        end else if (m_is_d ? !(dREN || dWEN) : !iREN) begin
          m_active = 0;
        end
      end else begin
        guard_hit = GUARD && iREN && (m_wins == MAX_DWINS);
        if ((dREN || dWEN) && !guard_hit) begin
          m_active = 1; m_is_d = 1; m_we = dWEN; m_addr = daddr; m_data = dstore;
        end else if (iREN) begin
          m_active = 1; m_is_d = 0; m_we = 0; m_addr = iaddr; m_data = 0;
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
